rr_dis_pipe: RTL and testbench

Parametrised register-read → dispatch pipeline stage for the out-of-order core. Carries LANES instruction slots per bundle under a valid/ready handshake with a two-entry skid buffer, so back-pressure from dispatch never needs a combinational stall path. It snoops the writeback bus so operands that become ready while a bundle waits are captured and marked valid. It flushes on branch recovery.

---
 rtl/rr_dis_pkg.sv | 50 +++++
 rtl/rr_dis_entry.sv | 41 ++++
 rtl/rr_dis_pipe.sv | 116 +++++++++++
 tb/tb_rr_dis_pipe.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_dis_pkg.sv
// Shared types for the register-read -> dispatch stage.
// RR_DIS_WAKEUP_EN enables the writeback operand snoop.
package rr_dis_pkg;

  localparam int LANES_DEF  = 2;
  localparam int CTRL_W_DEF = 134;
  localparam int PTAG_W_DEF = 6;
  localparam int DW_DEF     = 32;
  localparam int WB_DEF     = 2;

  typedef struct packed {
    logic                  lane_v;
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [PTAG_W_DEF-1:0] rs_p;
    logic [PTAG_W_DEF-1:0] rt_p;
    logic [DW_DEF-1:0]     rs_data;
    logic [DW_DEF-1:0]     rt_data;
    logic                  rs_den;
    logic                  rt_den;
  } lane_t;

  typedef lane_t [LANES_DEF-1:0] bundle_t;

`ifdef RR_DIS_WAKEUP_EN
  // Descending scan so the lowest matching port is written last.
  function automatic lane_t wake(
    lane_t                           l,
    logic [WB_DEF-1:0]               v,
    logic [WB_DEF*PTAG_W_DEF-1:0]    tag,
    logic [WB_DEF*DW_DEF-1:0]        data
  );
    lane_t r;
    r = l;
    for (int k = WB_DEF - 1; k >= 0; k--) begin
      if (l.lane_v && !l.rs_den && v[k] &&
          tag[k*PTAG_W_DEF +: PTAG_W_DEF] == l.rs_p) begin
        r.rs_data = data[k*DW_DEF +: DW_DEF];
        r.rs_den  = 1'b1;
      end
      if (l.lane_v && !l.rt_den && v[k] &&
          tag[k*PTAG_W_DEF +: PTAG_W_DEF] == l.rt_p) begin
        r.rt_data = data[k*DW_DEF +: DW_DEF];
        r.rt_den  = 1'b1;
      end
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/rr_dis_entry.sv
// One bundle of storage with in-place operand wakeup.
// Wakeup logic exists only when RR_DIS_WAKEUP_EN is defined.
module rr_dis_entry
  import rr_dis_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             v_nxt,
  input  logic                             ld,
  input  bundle_t                          d,
  input  logic [WB_DEF-1:0]                wb_valid,
  input  logic [WB_DEF*PTAG_W_DEF-1:0]     wb_tag,
  input  logic [WB_DEF*DW_DEF-1:0]         wb_data,
  output logic                             v,
  output bundle_t                          q,
  output bundle_t                          w
);

`ifdef RR_DIS_WAKEUP_EN
  always_comb begin
    w = q;
    for (int i = 0; i < LANES_DEF; i++)
      w[i] = wake(q[i], wb_valid, wb_tag, wb_data);
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_tag, wb_data};
  assign w = q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= 1'b0;
      q <= '0;
    end else begin
      v <= v_nxt;
      q <= ld ? d : w;
    end
  end

endmodule

// File: rtl/rr_dis_pipe.sv
// Register-read -> dispatch stage: M/S skid pair with wb snoop.
// Define RR_DIS_WAKEUP_EN to enable operand wakeup.
module rr_dis_pipe
  import rr_dis_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int PTAG_W = PTAG_W_DEF,
  parameter int DW     = DW_DEF,
  parameter int WB     = WB_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     recover,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_lane_v,
  input  logic [LANES*CTRL_W-1:0]  in_ctrl,
  input  logic [LANES*PTAG_W-1:0]  in_rs_p,
  input  logic [LANES*PTAG_W-1:0]  in_rt_p,
  input  logic [LANES*DW-1:0]      in_rs_data,
  input  logic [LANES*DW-1:0]      in_rt_data,
  input  logic [LANES-1:0]         in_rs_den,
  input  logic [LANES-1:0]         in_rt_den,
  input  logic [WB-1:0]            wb_valid,
  input  logic [WB*PTAG_W-1:0]     wb_tag,
  input  logic [WB*DW-1:0]         wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_lane_v,
  output logic [LANES*CTRL_W-1:0]  out_ctrl,
  output logic [LANES*PTAG_W-1:0]  out_rs_p,
  output logic [LANES*PTAG_W-1:0]  out_rt_p,
  output logic [LANES*DW-1:0]      out_rs_data,
  output logic [LANES*DW-1:0]      out_rt_data,
  output logic [LANES-1:0]         out_rs_den,
  output logic [LANES-1:0]         out_rt_den
);

  bundle_t in_b, in_w, m_d;
  bundle_t m_q, s_q, s_w, m_w_unused;
  logic    m_v, s_v, acc, rel;
  logic    m_ld, s_ld, m_v_nxt, s_v_nxt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign in_b[i] = '{
      lane_v:  in_lane_v[i],
      ctrl:    in_ctrl[i*CTRL_W +: CTRL_W],
      rs_p:    in_rs_p[i*PTAG_W +: PTAG_W],
      rt_p:    in_rt_p[i*PTAG_W +: PTAG_W],
      rs_data: in_rs_data[i*DW +: DW],
      rt_data: in_rt_data[i*DW +: DW],
      rs_den:  in_rs_den[i],
      rt_den:  in_rt_den[i]
    };
    assign out_lane_v[i]                = m_q[i].lane_v;
    assign out_ctrl[i*CTRL_W +: CTRL_W] = m_q[i].ctrl;
    assign out_rs_p[i*PTAG_W +: PTAG_W] = m_q[i].rs_p;
    assign out_rt_p[i*PTAG_W +: PTAG_W] = m_q[i].rt_p;
    assign out_rs_data[i*DW +: DW]      = m_q[i].rs_data;
    assign out_rt_data[i*DW +: DW]      = m_q[i].rt_data;
    assign out_rs_den[i]                = m_q[i].rs_den;
    assign out_rt_den[i]                = m_q[i].rt_den;
  end

`ifdef RR_DIS_WAKEUP_EN
  always_comb begin
    in_w = in_b;
    for (int i = 0; i < LANES; i++)
      in_w[i] = wake(in_b[i], wb_valid, wb_tag, wb_data);
  end
`else
  assign in_w = in_b;
`endif

  assign in_ready  = ~s_v;
  assign out_valid = m_v;
  assign acc       = in_valid & in_ready & ~recover;
  assign rel       = m_v & out_ready;

  // S can only be full when in_ready is low, so acc and S->M never collide.
  assign m_ld    = (rel & s_v) | (acc & (~m_v | rel));
  assign s_ld    = acc & m_v & ~rel;
  assign m_d     = s_v ? s_w : in_w;
  assign m_v_nxt = ~recover & (s_v | acc | (m_v & ~rel));
  assign s_v_nxt = ~recover & ((s_v & ~rel) | s_ld);

  rr_dis_entry u_m (
    .clk      (clk),
    .rst      (rst),
    .v_nxt    (m_v_nxt),
    .ld       (m_ld),
    .d        (m_d),
    .wb_valid (wb_valid),
    .wb_tag   (wb_tag),
    .wb_data  (wb_data),
    .v        (m_v),
    .q        (m_q),
    .w        (m_w_unused)
  );

  rr_dis_entry u_s (
    .clk      (clk),
    .rst      (rst),
    .v_nxt    (s_v_nxt),
    .ld       (s_ld),
    .d        (in_w),
    .wb_valid (wb_valid),
    .wb_tag   (wb_tag),
    .wb_data  (wb_data),
    .v        (s_v),
    .q        (s_q),
    .w        (s_w)
  );

endmodule

// File: tb/tb_rr_dis_pipe.sv
// Randomised bench for rr_dis_pipe against a queue-based model.
// Expectations follow RR_DIS_WAKEUP_EN when it is defined.
module tb_rr_dis_pipe;

  localparam int L   = 2;
  localparam int CW  = 134;
  localparam int TW  = 6;
  localparam int DW  = 32;
  localparam int WBN = 2;
  localparam int PLW = L * (1 + CW + 2*TW + 2*DW + 2);

  logic clk = 1'b0;
  logic rst, recover, in_valid, in_ready, out_valid, out_ready;
  logic [L-1:0]      in_lane_v, in_rs_den, in_rt_den;
  logic [L*CW-1:0]   in_ctrl;
  logic [L*TW-1:0]   in_rs_p, in_rt_p;
  logic [L*DW-1:0]   in_rs_data, in_rt_data;
  logic [WBN-1:0]    wb_valid;
  logic [WBN*TW-1:0] wb_tag;
  logic [WBN*DW-1:0] wb_data;
  logic [L-1:0]      out_lane_v, out_rs_den, out_rt_den;
  logic [L*CW-1:0]   out_ctrl;
  logic [L*TW-1:0]   out_rs_p, out_rt_p;
  logic [L*DW-1:0]   out_rs_data, out_rt_data;
  logic [PLW-1:0]    dut_pl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_dis_pipe dut (
    .clk(clk), .rst(rst), .recover(recover),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_v(in_lane_v), .in_ctrl(in_ctrl),
    .in_rs_p(in_rs_p), .in_rt_p(in_rt_p),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_rs_den(in_rs_den), .in_rt_den(in_rt_den),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_v(out_lane_v), .out_ctrl(out_ctrl),
    .out_rs_p(out_rs_p), .out_rt_p(out_rt_p),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
    .out_rs_den(out_rs_den), .out_rt_den(out_rt_den)
  );

  assign dut_pl = {out_lane_v, out_ctrl, out_rs_p, out_rt_p,
                   out_rs_data, out_rt_data, out_rs_den, out_rt_den};

  typedef struct {
    bit          lv;
    bit [CW-1:0] ctrl;
    bit [TW-1:0] rs_p, rt_p;
    bit [DW-1:0] rs_d, rt_d;
    bit          rs_e, rt_e;
  } ml_t;
  typedef ml_t mb_t [L];

  // Bundles held by the stage, oldest first; size 2 means skid is full.
  mb_t mq[$];

  function automatic mb_t cap_in();
    mb_t b;
    for (int l = 0; l < L; l++) begin
      b[l].lv   = in_lane_v[l];
      b[l].ctrl = in_ctrl[l*CW +: CW];
      b[l].rs_p = in_rs_p[l*TW +: TW];
      b[l].rt_p = in_rt_p[l*TW +: TW];
      b[l].rs_d = in_rs_data[l*DW +: DW];
      b[l].rt_d = in_rt_data[l*DW +: DW];
      b[l].rs_e = in_rs_den[l];
      b[l].rt_e = in_rt_den[l];
    end
    return b;
  endfunction

  function automatic logic [PLW-1:0] exp_pl(mb_t b);
    logic [L-1:0]    lv, re, te;
    logic [L*CW-1:0] c;
    logic [L*TW-1:0] rp, tp;
    logic [L*DW-1:0] rd, td;
    for (int l = 0; l < L; l++) begin
      lv[l] = b[l].lv;
      c[l*CW +: CW] = b[l].ctrl;
      rp[l*TW +: TW] = b[l].rs_p;
      tp[l*TW +: TW] = b[l].rt_p;
      rd[l*DW +: DW] = b[l].rs_d;
      td[l*DW +: DW] = b[l].rt_d;
      re[l] = b[l].rs_e;
      te[l] = b[l].rt_e;
    end
    return {lv, c, rp, tp, rd, td, re, te};
  endfunction

  function automatic mb_t mwake(mb_t b);
    mb_t r;
    r = b;
`ifdef RR_DIS_WAKEUP_EN
    for (int l = 0; l < L; l++) begin
      if (b[l].lv && !b[l].rs_e)
        for (int k = 0; k < WBN; k++)
          if (wb_valid[k] && wb_tag[k*TW +: TW] == b[l].rs_p) begin
            r[l].rs_d = wb_data[k*DW +: DW];
            r[l].rs_e = 1'b1;
            break;
          end
      if (b[l].lv && !b[l].rt_e)
        for (int k = 0; k < WBN; k++)
          if (wb_valid[k] && wb_tag[k*TW +: TW] == b[l].rt_p) begin
            r[l].rt_d = wb_data[k*DW +: DW];
            r[l].rt_e = 1'b1;
            break;
          end
    end
`endif
    return r;
  endfunction

  // Advance the model by one clock using the current inputs.
  task automatic step();
    bit acc, rel;
    acc = in_valid && mq.size() < 2 && !recover;
    rel = mq.size() > 0 && out_ready;
    foreach (mq[i]) mq[i] = mwake(mq[i]);
    if (rel) void'(mq.pop_front());
    if (acc) mq.push_back(mwake(cap_in()));
    if (recover) mq.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_in(int pv, int pr, int pwb);
    in_valid  = ($urandom_range(0, 99) < pv);
    out_ready = ($urandom_range(0, 99) < pr);
    in_lane_v = L'($urandom);
    in_rs_den = L'($urandom);
    in_rt_den = L'($urandom);
    for (int b = 0; b < L*CW; b++) in_ctrl[b] = 1'($urandom);
    for (int l = 0; l < L; l++) begin
      in_rs_p[l*TW +: TW]    = TW'($urandom_range(0, 7));
      in_rt_p[l*TW +: TW]    = TW'($urandom_range(0, 7));
      in_rs_data[l*DW +: DW] = $urandom;
      in_rt_data[l*DW +: DW] = $urandom;
    end
    for (int k = 0; k < WBN; k++) begin
      wb_valid[k]          = ($urandom_range(0, 99) < pwb);
      wb_tag[k*TW +: TW]   = TW'($urandom_range(0, 7));
      wb_data[k*DW +: DW]  = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; recover = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rand_in(0, 0, 0);
    @(negedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got %b exp 0", out_valid); errors++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got %b exp 1", in_ready); errors++;
    end
    checks++;
    if (dut_pl !== '0) begin
      $display("FAIL reset_payload got %h exp 0", dut_pl); errors++;
    end
    rst = 1'b1;
    mq.delete();
  endtask

  task automatic test_basic();
    rand_in(100, 100, 0);
    in_lane_v[0] = 1'b1;
    in_rs_p[TW-1:0] = TW'(5);
    in_rs_den[0] = 1'b1;
    in_rs_data[DW-1:0] = 32'h1234;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL basic_valid got %b exp 1", out_valid); errors++;
    end
    checks++;
    if (out_rs_data[DW-1:0] !== 32'h1234) begin
      $display("FAIL basic_rs_data got %h exp 1234", out_rs_data[DW-1:0]);
      errors++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL basic_in_ready got %b exp 1", in_ready); errors++;
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL basic_drain got %b exp 0", out_valid); errors++;
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      rand_in(100, 100, 50);
      step();
      checks++;
      if (out_valid !== 1'b1) begin
        $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); errors++;
      end
      checks++;
      if (mq.size() > 0 && dut_pl !== exp_pl(mq[0])) begin
        $display("FAIL stream_data[%0d] got %h exp %h", i, dut_pl, exp_pl(mq[0]));
        errors++;
      end
    end
    in_valid = 1'b0; wb_valid = '0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL stream_end got %b exp 0", out_valid); errors++;
    end
  endtask

  task automatic test_backpressure();
    bit got;
    for (int i = 0; i < 3; i++) begin
      rand_in(100, 0, 0);
      step();
      if (i == 1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          $display("FAIL bp_in_ready got %b exp 0", in_ready); errors++;
        end
      end
      checks++;
      if (mq.size() > 0 && dut_pl !== exp_pl(mq[0])) begin
        $display("FAIL bp_hold[%0d] got %h exp %h", i, dut_pl, exp_pl(mq[0]));
        errors++;
      end
    end
    out_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !(got && mq.size() == 0); c++) begin
      if (in_valid && mq.size() < 2) got = 1'b1;
      step();
      if (got) in_valid = 1'b0;
      checks++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
        $display("FAIL bp_ctl[%0d] got v=%b r=%b exp v=%b r=%b", c,
                 out_valid, in_ready, mq.size() > 0, mq.size() < 2);
        errors++;
      end
      checks++;
      if (mq.size() > 0 && dut_pl !== exp_pl(mq[0])) begin
        $display("FAIL bp_order[%0d] got %h exp %h", c, dut_pl, exp_pl(mq[0]));
        errors++;
      end
    end
    checks++;
    if (!got || mq.size() != 0) begin
      $display("FAIL bp_timeout got accepted=%b left=%0d exp 1/0", got, mq.size());
      errors++;
    end
  endtask

  task automatic test_wakeup();
    logic [DW-1:0] orig, exp_d;
    logic          exp_e;
    rand_in(100, 0, 0);
    in_lane_v = 2'b11;
    in_rs_den = 2'b11;
    in_rt_den = 2'b01;
    in_rt_p[2*TW-1:TW] = TW'(12);
    orig = in_rt_data[2*DW-1:DW];
    step();
    in_valid = 1'b0;
    wb_valid = 2'b11;
    wb_tag   = {TW'(12), TW'(12)};
    wb_data  = {32'hBBBB, 32'hAAAA};
    step();
`ifdef RR_DIS_WAKEUP_EN
    exp_e = 1'b1; exp_d = 32'hAAAA;
`else
    exp_e = 1'b0; exp_d = orig;
`endif
    checks++;
    if (out_rt_den[1] !== exp_e) begin
      $display("FAIL wake_den got %b exp %b", out_rt_den[1], exp_e); errors++;
    end
    checks++;
    if (out_rt_data[2*DW-1:DW] !== exp_d) begin
      $display("FAIL wake_data got %h exp %h", out_rt_data[2*DW-1:DW], exp_d);
      errors++;
    end
    checks++;
    if (mq.size() > 0 && dut_pl !== exp_pl(mq[0])) begin
      $display("FAIL wake_bundle got %h exp %h", dut_pl, exp_pl(mq[0]));
      errors++;
    end
    wb_valid = '0; out_ready = 1'b1;
    step();
  endtask

  task automatic test_recover();
    for (int i = 0; i < 2; i++) begin
      rand_in(100, 0, 0);
      step();
    end
    rand_in(100, 100, 0);
    recover = 1'b1;
    step();
    recover = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL rec_valid got %b exp 0", out_valid); errors++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL rec_ready got %b exp 1", in_ready); errors++;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL rec_ghost[%0d] got %b exp 0", c, out_valid); errors++;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rand_in(70, 60, 40);
      recover = ($urandom_range(0, 19) == 0);
      step();
      checks++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
        $display("FAIL rnd_ctl[%0d] got v=%b r=%b exp v=%b r=%b", c,
                 out_valid, in_ready, mq.size() > 0, mq.size() < 2);
        errors++;
      end
      checks++;
      if (mq.size() > 0 && dut_pl !== exp_pl(mq[0])) begin
        $display("FAIL rnd_data[%0d] got %h exp %h", c, dut_pl, exp_pl(mq[0]));
        errors++;
      end
    end
    recover = 1'b0;
  endtask

  task automatic test_async_reset();
    rand_in(100, 0, 0);
    step();
    step();
    #3;
    rst = 1'b0;
    #1;
    mq.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL arst_ctl got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
      errors++;
    end
    checks++;
    if (dut_pl !== '0) begin
      $display("FAIL arst_payload got %h exp 0", dut_pl); errors++;
    end
    @(negedge clk);
    rst = 1'b1;
    rand_in(100, 0, 0);
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL arst_first got %b exp 1", out_valid); errors++;
    end
    checks++;
    if (mq.size() > 0 && dut_pl !== exp_pl(mq[0])) begin
      $display("FAIL arst_data got %h exp %h", dut_pl, exp_pl(mq[0]));
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_wakeup();
    test_recover();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
